// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state encoding, also used by the receiver and baud generator.
package uart_pkg;

   localparam int OVERSAMPLE      = 16;
   localparam int D_BIT_DEFAULT   = 8;
   localparam int SB_TICK_DEFAULT = 16;

   // Three bits so the optional PARITY state fits alongside the others.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmit FSMD: start bit, D_BIT data bits LSB first, optional even parity, SB_TICK-tick stop period.
// Define UART_TX_PARITY_EN to insert the PARITY state after the data bits.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int D_BIT   = D_BIT_DEFAULT,
   parameter int SB_TICK = SB_TICK_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_start,
   input  logic             s_tick,
   input  logic [D_BIT-1:0] din,
   output logic             tx_busy,
   output logic             tx_done_tick,
   output logic             tx
);

   localparam logic [4:0] LastTick = 5'(OVERSAMPLE - 1);
   localparam logic [4:0] LastStop = 5'(SB_TICK - 1);
   localparam logic [2:0] LastBit  = 3'(D_BIT - 1);

   tx_state_e        state_q, state_d;
   logic [4:0]       s_q, s_d;
   logic [2:0]       n_q, n_d;
   logic [D_BIT-1:0] b_q, b_d;
   logic             tx_q, tx_d;
   logic             doneTick;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   // Next-state logic; tx_d is derived from the state being entered so the pin comes straight off a flop.
   always_comb begin
      state_d  = state_q;
      s_d      = s_q;
      n_d      = n_q;
      b_d      = b_q;
      doneTick = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = par_q;
`endif
      case (state_q)
         IDLE: begin
            if (tx_start) begin
               b_d     = din;
               s_d     = 5'd0;
               state_d = START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^din;
`endif
            end
         end
         START: begin
            if (s_tick) begin
               if (s_q == LastTick) begin
                  s_d     = 5'd0;
                  n_d     = 3'd0;
                  state_d = DATA;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (s_q == LastTick) begin
                  s_d = 5'd0;
                  b_d = b_q >> 1;
                  if (n_q == LastBit) begin
`ifdef UART_TX_PARITY_EN
                     state_d = PARITY;
`else
                     state_d = STOP;
`endif
                  end else begin
                     n_d = n_q + 3'd1;
                  end
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (s_tick) begin
               if (s_q == LastTick) begin
                  s_d     = 5'd0;
                  state_d = STOP;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
`endif
         STOP: begin
            if (s_tick) begin
               if (s_q == LastStop) begin
                  s_d      = 5'd0;
                  doneTick = 1'b1;
                  state_d  = IDLE;
               end else begin
                  s_d = s_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_d = par_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   // State and datapath registers; reset aborts any frame and returns the line high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= 5'd0;
         n_q     <= 3'd0;
         b_q     <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         n_q     <= n_d;
         b_q     <= b_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx           = tx_q;
   assign tx_busy      = (state_q != IDLE);
   assign tx_done_tick = doneTick;

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench: two transmitters (1 and 2 stop bits) share stimulus; a monitor rebuilds each frame per s_tick.
`timescale 1ns/1ps
module tb_uart_transmitter;

   localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
   localparam int PBITS = 1;
`else
   localparam int PBITS = 0;
`endif
   localparam int NDUT   = 2;
   localparam int MAXT   = 512;
   localparam int BUDGET = 4000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            txStart = 1'b0;
   logic            sTick = 1'b0;
   logic [DBIT-1:0] din = '0;
   logic [1:0]      txW, busyW, doneW;

   int compared = 0;
   int mismatched = 0;

   int tickEn = 1;
   int tickDiv = 1;
   int tickCnt = 0;

   logic [7:0] expQ0[$];
   logic [7:0] expQ1[$];

   int   sbOf[NDUT] = '{16, 32};
   int   active[NDUT];
   int   nTicks[NDUT];
   int   gapCnt[NDUT];
   int   lastGap[NDUT];
   int   framesDone[NDUT];
   int   busyOk[NDUT];
   logic samp[NDUT][MAXT];

   uart_transmitter #(.D_BIT(DBIT), .SB_TICK(16)) dut (
      .clk(clk), .rst(rst), .tx_start(txStart), .s_tick(sTick), .din(din),
      .tx_busy(busyW[0]), .tx_done_tick(doneW[0]), .tx(txW[0])
   );

   uart_transmitter #(.D_BIT(DBIT), .SB_TICK(32)) dut32 (
      .clk(clk), .rst(rst), .tx_start(txStart), .s_tick(sTick), .din(din),
      .tx_busy(busyW[1]), .tx_done_tick(doneW[1]), .tx(txW[1])
   );

   always #5 clk = ~clk;

   // Reference frame: each serial bit is OVERSAMPLE s_ticks wide, stop period is sb s_ticks of high.
   function automatic logic expTx(input logic [7:0] w, input int k);
      int dataEnd;
      dataEnd = 16 + 16 * DBIT;
      if (k < 16) return 1'b0;
      if (k < dataEnd) return w[(k - 16) / 16];
      if (k < dataEnd + 16 * PBITS) return ^w;
      return 1'b1;
   endfunction

   task automatic checkValue(input string nm, input int act, input int req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, required %0d", nm, act, req);
      end
   endtask

   task automatic checkOutput(input int i);
      logic [7:0] w;
      int expLen;
      int bad;
      int lim;
      expLen = 16 * (1 + DBIT + PBITS) + sbOf[i];
      compared++;
      if ((i == 0 && expQ0.size() == 0) || (i == 1 && expQ1.size() == 0)) begin
         mismatched++;
         $display("[TB] FAIL frameUnexpected dut%0d: done pulse with %0d s_ticks, required no frame", i, nTicks[i]);
         return;
      end
      w = (i == 0) ? expQ0.pop_front() : expQ1.pop_front();
      if (nTicks[i] != expLen) begin
         mismatched++;
         $display("[TB] FAIL frameLen dut%0d word %h: %0d s_ticks, required %0d", i, w, nTicks[i], expLen);
      end
      compared++;
      bad = -1;
      lim = (nTicks[i] < expLen) ? nTicks[i] : expLen;
      if (lim > MAXT) lim = MAXT;
      for (int k = 0; k < lim; k++) begin
         if (bad < 0 && samp[i][k] !== expTx(w, k)) bad = k;
      end
      if (bad >= 0) begin
         mismatched++;
         $display("[TB] FAIL frameBits dut%0d word %h tick %0d: tx=%b, required %b",
                  i, w, bad, samp[i][bad], expTx(w, bad));
      end
      compared++;
      if (busyOk[i] == 0) begin
         mismatched++;
         $display("[TB] FAIL frameBusy dut%0d word %h: tx_busy dropped mid-frame, required 1", i, w);
      end
   endtask

   // Shared s_tick source: divides the clock by tickDiv while enabled.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tickCnt = (tickCnt + 1) % tickDiv;
         sTick = (tickEn != 0) && (tickCnt == 0);
      end
   end

   // Monitor: records tx on every s_tick of a frame and scores it when tx_done_tick arrives.
   initial begin
      for (int i = 0; i < NDUT; i++) begin
         active[i] = 0; nTicks[i] = 0; gapCnt[i] = 0; lastGap[i] = 0; framesDone[i] = 0; busyOk[i] = 1;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
               active[i] = 0;
               nTicks[i] = 0;
               gapCnt[i] = 0;
            end else begin
               if (active[i] == 0) begin
                  if (doneW[i]) begin
                     compared++;
                     mismatched++;
                     $display("[TB] FAIL idleDone dut%0d: tx_done_tick=1 outside a frame, required 0", i);
                  end
                  if (txW[i] == 1'b0) begin
                     active[i]  = 1;
                     nTicks[i]  = 0;
                     busyOk[i]  = 1;
                     lastGap[i] = gapCnt[i];
                  end else begin
                     gapCnt[i]++;
                  end
               end
               if (active[i] != 0) begin
                  if (busyW[i] !== 1'b1) busyOk[i] = 0;
                  if (sTick) begin
                     if (nTicks[i] < MAXT) samp[i][nTicks[i]] = txW[i];
                     nTicks[i]++;
                  end
                  if (doneW[i]) begin
                     checkOutput(i);
                     active[i] = 0;
                     gapCnt[i] = 0;
                     framesDone[i]++;
                  end
               end
            end
         end
      end
   end

   task automatic waitIdle();
      int budget;
      budget = 0;
      @(negedge clk);
      while (busyW != 2'b00 && budget < BUDGET) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= BUDGET) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL idleTimeout: tx_busy=%b after %0d cycles, required 00", busyW, budget);
         @(posedge clk); #1; rst = 1'b1; txStart = 1'b0;
         expQ0.delete(); expQ1.delete();
         @(posedge clk); #1; rst = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] word, input bit noise);
      waitIdle();
      @(posedge clk); #1;
      txStart = 1'b1;
      din = word;
      expQ0.push_back(word);
      expQ1.push_back(word);
      @(posedge clk); #1;
      txStart = 1'b0;
      din = DBIT'($urandom);
      if (noise) begin
         repeat (8) begin
            @(posedge clk); #1;
            txStart = 1'($urandom_range(0, 1));
            din = DBIT'($urandom);
         end
         txStart = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int startCount;
      int budget;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checkValue($sformatf("resetTx%0d", i), int'(txW[i]), 1);
         checkValue($sformatf("resetBusy%0d", i), int'(busyW[i]), 0);
         checkValue($sformatf("resetDone%0d", i), int'(doneW[i]), 0);
      end
      @(posedge clk); #1; rst = 1'b0;

      tickDiv = 1;
      applyStimulus(8'h55, 1'b0);
      tickDiv = 4;
      applyStimulus(8'hA3, 1'b0);
      tickDiv = 1;
      applyStimulus(8'h0F, 1'b0);
      applyStimulus(8'h07, 1'b0);

      // Continuous tx_start: frames must follow each other with a single idle-high cycle.
      waitIdle();
      @(posedge clk); #1;
      txStart = 1'b1; din = 8'h00;
      expQ0.push_back(8'h00); expQ1.push_back(8'h00);
      @(posedge clk); #1;
      din = 8'hFF;
      expQ0.push_back(8'hFF); expQ1.push_back(8'hFF);
      startCount = framesDone[1];
      budget = 0;
      while (framesDone[1] == startCount && budget < BUDGET) begin
         @(negedge clk);
         budget++;
      end
      checkValue("backToBackTimeout", int'(budget < BUDGET), 1);
      repeat (3) @(posedge clk);
      #1; txStart = 1'b0;
      waitIdle();
      checkValue("gapCycles0", lastGap[0], 1);
      checkValue("gapCycles1", lastGap[1], 1);

      // Reset during data bit 3 (a zero bit of 8'h35) aborts the frame cleanly.
      applyStimulus(8'h35, 1'b0);
      repeat (69) @(posedge clk);
      #1; rst = 1'b1;
      expQ0.delete(); expQ1.delete();
      @(negedge clk);
      checkValue("preResetTx0", int'(txW[0]), 0);
      checkValue("preResetTx1", int'(txW[1]), 0);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         checkValue($sformatf("abortTx%0d", i), int'(txW[i]), 1);
         checkValue($sformatf("abortBusy%0d", i), int'(busyW[i]), 0);
         checkValue($sformatf("abortDone%0d", i), int'(doneW[i]), 0);
      end
      repeat (200) @(negedge clk);
      applyStimulus(8'h5A, 1'b0);

      // No s_tick after acceptance: the frame must sit in its start bit.
      waitIdle();
      tickEn = 0;
      applyStimulus(8'h96, 1'b0);
      repeat (100) @(negedge clk);
      checkValue("stallTx0", int'(txW[0]), 0);
      checkValue("stallTx1", int'(txW[1]), 0);
      checkValue("stallBusy0", int'(busyW[0]), 1);
      checkValue("stallBusy1", int'(busyW[1]), 1);
      tickEn = 1;

      for (int f = 0; f < 12; f++) begin
         tickDiv = $urandom_range(1, 3);
         applyStimulus(8'($urandom), 1'b1);
      end

      waitIdle();
      repeat (5) @(negedge clk);
      checkValue("queueEmpty0", expQ0.size(), 0);
      checkValue("queueEmpty1", expQ1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
